// File: rtl/bank_biu_pkg.sv
// Shared constants, types and helpers for the bank-side BIU read path.
package bank_biu_pkg;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [7:0] LINE_ARLEN       = 8'd1;
    localparam logic [2:0] LINE_ARSIZE      = 3'd4;
    localparam int         LINE_OFFSET_BITS = 5;
    localparam int         ID_WIDTH         = 6;

    // R-channel line assembly states
    typedef enum logic [1:0] {
        R_LO,
        R_HI,
        R_OUT
    } r_state_e;

    // Transaction ID used on AXI and toward the ISU: {set, way}
    function automatic logic [ID_WIDTH-1:0] make_id(input logic [2:0] set_v, input logic [2:0] way_v);
        return {set_v, way_v};
    endfunction

endpackage

// File: rtl/bank_biu_req_fifo.sv
// Small synchronous FIFO holding pending linefill requests ({line address, id}).
module bank_biu_req_fifo #(
    parameter int DATA_WIDTH = 33,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]        wr_ptr_q;
    logic [PTR_W:0]        rd_ptr_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[PTR_W-1:0]];

    // Pointers carry one extra wrap bit so full and empty can be told apart
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read as valid
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/bank_biu_linefill_rd.sv
// Bank-side BIU read path: queues linefill requests, issues 2-beat AXI reads,
// assembles 256-bit lines for the ISU and tracks in-flight {set,way} IDs.
module bank_biu_linefill_rd
    import bank_biu_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  htu_biu_req_valid_i,
    output logic                  htu_biu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] htu_biu_req_addr_i,
    input  logic [2:0]            htu_biu_req_set_i,
    input  logic [2:0]            htu_biu_req_way_i,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [5:0]            axi_arid_o,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic [127:0]          axi_rdata_i,
    input  logic [5:0]            axi_rid_i,
    input  logic                  axi_rlast_i,
    input  logic [1:0]            axi_rresp_i,
    output logic                  biu_isu_rvalid_o,
    input  logic                  biu_isu_rready_i,
    output logic [255:0]          biu_isu_rdata_o,
    output logic [5:0]            biu_isu_rid_o,
    output logic                  biu_err_o
);

    localparam int LINE_ADDR_W = ADDR_WIDTH - LINE_OFFSET_BITS;
    localparam int ENTRY_W     = LINE_ADDR_W + ID_WIDTH;
    localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [ID_WIDTH-1:0]    req_id;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_wdata;
    logic [ENTRY_W-1:0]     fifo_head;
    logic                   ar_hs;
    logic                   isu_hs;
    logic                   clearing_same_id;
    logic                   resp_bad;
    logic                   take_lo;
    logic                   unused_addr_bits;

    logic [63:0]            inflight_q;
    logic [CNT_W-1:0]       outstanding_q;

    r_state_e               state_q, state_d;
    logic [127:0]           lo_q, lo_d;
    logic [ID_WIDTH-1:0]    cur_id_q, cur_id_d;
    logic [255:0]           out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
    logic                   out_valid_q, out_valid_d;
    logic                   err_q, err_d;

    assign unused_addr_bits = ^htu_biu_req_addr_i[LINE_OFFSET_BITS-1:0];

    assign req_id           = make_id(htu_biu_req_set_i, htu_biu_req_way_i);
    assign isu_hs           = out_valid_q && biu_isu_rready_i;
    assign clearing_same_id = isu_hs && (out_id_q == req_id);

    assign htu_biu_req_ready_o = !fifo_full && !inflight_q[req_id] && !clearing_same_id;
    assign fifo_push  = htu_biu_req_valid_i && htu_biu_req_ready_o;
    assign fifo_wdata = {htu_biu_req_addr_i[ADDR_WIDTH-1:LINE_OFFSET_BITS], req_id};

    bank_biu_req_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (fifo_push),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign axi_arvalid_o = !fifo_empty && (outstanding_q < MAX_CNT);
    assign ar_hs         = axi_arvalid_o && axi_arready_i;
    assign fifo_pop      = ar_hs;
    assign axi_araddr_o  = {fifo_head[ENTRY_W-1:ID_WIDTH], {LINE_OFFSET_BITS{1'b0}}};
    assign axi_arid_o    = fifo_head[ID_WIDTH-1:0];
    assign axi_arlen_o   = LINE_ARLEN;
    assign axi_arsize_o  = LINE_ARSIZE;
    assign axi_arburst_o = AXI_BURST_INCR;

    assign biu_isu_rvalid_o = out_valid_q;
    assign biu_isu_rdata_o  = out_data_q;
    assign biu_isu_rid_o    = out_id_q;
    assign biu_err_o        = err_q;

    // An ID is marked busy at enqueue and released when its line leaves for the ISU
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else begin
            if (isu_hs)    inflight_q[out_id_q] <= 1'b0;
            if (fifo_push) inflight_q[req_id]   <= 1'b1;
        end
    end

    // Count ARs issued whose lines have not yet been handed to the ISU
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else begin
            case ({ar_hs, isu_hs})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign resp_bad = (axi_rresp_i != AXI_RESP_OKAY);

    // R-channel FSM: collect beat0 into lo, beat1 completes the line into the output register
    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        cur_id_d     = cur_id_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        out_valid_d  = out_valid_q;
        err_d        = err_q;
        axi_rready_o = 1'b1;
        take_lo      = 1'b0;

        case (state_q)
            R_LO: begin
                take_lo = axi_rvalid_i;
            end
            R_HI: begin
                if (axi_rvalid_i) begin
                    out_data_d  = {axi_rdata_i, lo_q};
                    out_id_d    = cur_id_q;
                    out_valid_d = 1'b1;
                    state_d     = R_OUT;
                    if ((axi_rid_i != cur_id_q) || !axi_rlast_i || resp_bad) err_d = 1'b1;
                end
            end
            R_OUT: begin
                axi_rready_o = biu_isu_rready_i;
                if (isu_hs) begin
                    out_valid_d = 1'b0;
                    state_d     = R_LO;
                    take_lo     = axi_rvalid_i;
                end
            end
            default: begin
                state_d = R_LO;
            end
        endcase

        if (take_lo) begin
            if (resp_bad) err_d = 1'b1;
            if (axi_rlast_i) begin
                err_d   = 1'b1;
                state_d = R_LO;
            end else begin
                lo_d     = axi_rdata_i;
                cur_id_d = axi_rid_i;
                state_d  = R_HI;
            end
        end
    end

    // R-channel state and output line registers; reset discards any partial line
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= R_LO;
            lo_q        <= '0;
            cur_id_q    <= '0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            cur_id_q    <= cur_id_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_bank_biu_linefill_rd.sv
// Directed self-checking bench for bank_biu_linefill_rd.
module tb_bank_biu_linefill_rd;

    logic         clk;
    logic         rst;
    logic         htu_biu_req_valid_i;
    logic         htu_biu_req_ready_o;
    logic [31:0]  htu_biu_req_addr_i;
    logic [2:0]   htu_biu_req_set_i;
    logic [2:0]   htu_biu_req_way_i;
    logic         axi_arvalid_o;
    logic         axi_arready_i;
    logic [31:0]  axi_araddr_o;
    logic [5:0]   axi_arid_o;
    logic [7:0]   axi_arlen_o;
    logic [2:0]   axi_arsize_o;
    logic [1:0]   axi_arburst_o;
    logic         axi_rvalid_i;
    logic         axi_rready_o;
    logic [127:0] axi_rdata_i;
    logic [5:0]   axi_rid_i;
    logic         axi_rlast_i;
    logic [1:0]   axi_rresp_i;
    logic         biu_isu_rvalid_o;
    logic         biu_isu_rready_i;
    logic [255:0] biu_isu_rdata_o;
    logic [5:0]   biu_isu_rid_o;
    logic         biu_err_o;

    int checks = 0;
    int errors = 0;
    int ar_count;

    bank_biu_linefill_rd #(
        .ADDR_WIDTH      (32),
        .REQ_DEPTH       (4),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .htu_biu_req_valid_i (htu_biu_req_valid_i),
        .htu_biu_req_ready_o (htu_biu_req_ready_o),
        .htu_biu_req_addr_i  (htu_biu_req_addr_i),
        .htu_biu_req_set_i   (htu_biu_req_set_i),
        .htu_biu_req_way_i   (htu_biu_req_way_i),
        .axi_arvalid_o       (axi_arvalid_o),
        .axi_arready_i       (axi_arready_i),
        .axi_araddr_o        (axi_araddr_o),
        .axi_arid_o          (axi_arid_o),
        .axi_arlen_o         (axi_arlen_o),
        .axi_arsize_o        (axi_arsize_o),
        .axi_arburst_o       (axi_arburst_o),
        .axi_rvalid_i        (axi_rvalid_i),
        .axi_rready_o        (axi_rready_o),
        .axi_rdata_i         (axi_rdata_i),
        .axi_rid_i           (axi_rid_i),
        .axi_rlast_i         (axi_rlast_i),
        .axi_rresp_i         (axi_rresp_i),
        .biu_isu_rvalid_o    (biu_isu_rvalid_o),
        .biu_isu_rready_i    (biu_isu_rready_i),
        .biu_isu_rdata_o     (biu_isu_rdata_o),
        .biu_isu_rid_o       (biu_isu_rid_o),
        .biu_err_o           (biu_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count AR handshakes so the outstanding limit can be observed
    always @(posedge clk) begin
        if (rst) ar_count <= 0;
        else if (axi_arvalid_o && axi_arready_i) ar_count <= ar_count + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one linefill request and hold it until accepted
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] s, input logic [2:0] w);
        int waited = 0;
        htu_biu_req_valid_i = 1'b1;
        htu_biu_req_addr_i  = addr;
        htu_biu_req_set_i   = s;
        htu_biu_req_way_i   = w;
        #1;
        while (!htu_biu_req_ready_o && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("req_accept", htu_biu_req_ready_o, 1'b1);
        tick();
        htu_biu_req_valid_i = 1'b0;
        #1;
    endtask

    // Present one R beat and hold it until accepted
    task automatic sendBeat(input logic [127:0] data, input logic [5:0] id, input logic last, input logic [1:0] resp);
        int waited = 0;
        axi_rvalid_i = 1'b1;
        axi_rdata_i  = data;
        axi_rid_i    = id;
        axi_rlast_i  = last;
        axi_rresp_i  = resp;
        #1;
        while (!axi_rready_o && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("r_accept", axi_rready_o, 1'b1);
        tick();
        axi_rvalid_i = 1'b0;
        axi_rlast_i  = 1'b0;
        axi_rresp_i  = 2'b00;
        #1;
    endtask

    // Accept the currently presented ISU line
    task automatic drainLine();
        biu_isu_rready_i = 1'b1;
        #1;
        tick();
        biu_isu_rready_i = 1'b0;
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        htu_biu_req_valid_i = 1'b0;
        axi_rvalid_i = 1'b0;
        biu_isu_rready_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [127:0] lo_v;
        logic [127:0] hi_v;

        rst = 1'b1;
        htu_biu_req_valid_i = 1'b0;
        htu_biu_req_addr_i  = '0;
        htu_biu_req_set_i   = '0;
        htu_biu_req_way_i   = '0;
        axi_arready_i       = 1'b0;
        axi_rvalid_i        = 1'b0;
        axi_rdata_i         = '0;
        axi_rid_i           = '0;
        axi_rlast_i         = 1'b0;
        axi_rresp_i         = 2'b00;
        biu_isu_rready_i    = 1'b0;

        // Reset state, constant AR fields while reset is held
        tick();
        tick();
        checkOutput("rst_rvalid",  biu_isu_rvalid_o, 1'b0);
        checkOutput("rst_rdata",   biu_isu_rdata_o, 256'h0);
        checkOutput("rst_rid",     biu_isu_rid_o, 6'd0);
        checkOutput("rst_arvalid", axi_arvalid_o, 1'b0);
        checkOutput("rst_err",     biu_err_o, 1'b0);
        checkOutput("rst_arlen",   axi_arlen_o, 8'd1);
        checkOutput("rst_arsize",  axi_arsize_o, 3'd4);
        checkOutput("rst_arburst", axi_arburst_o, 2'b01);
        checkOutput("rst_rready",  axi_rready_o, 1'b1);
        rst = 1'b0;
        tick();
        checkOutput("idle_req_ready", htu_biu_req_ready_o, 1'b1);

        // Single request, low address bits ignored, ARID = {3,5} = 29
        $display("[TB] single request");
        axi_arready_i = 1'b1;
        htu_biu_req_valid_i = 1'b1;
        htu_biu_req_addr_i  = 32'h1234_567B;
        htu_biu_req_set_i   = 3'd3;
        htu_biu_req_way_i   = 3'd5;
        #1;
        checkOutput("t1_ready", htu_biu_req_ready_o, 1'b1);
        checkOutput("t1_no_bypass", axi_arvalid_o, 1'b0);
        tick();
        htu_biu_req_valid_i = 1'b0;
        #1;
        checkOutput("t1_arvalid", axi_arvalid_o, 1'b1);
        checkOutput("t1_araddr", axi_araddr_o, 32'h1234_5660);
        checkOutput("t1_arid", axi_arid_o, 6'd29);
        checkOutput("t1_arlen", axi_arlen_o, 8'd1);
        tick();
        checkOutput("t1_ar_popped", axi_arvalid_o, 1'b0);
        lo_v = {4{32'hAAAA_0001}};
        hi_v = {4{32'hBBBB_0002}};
        sendBeat(lo_v, 6'd29, 1'b0, 2'b00);
        checkOutput("t1_no_early_rvalid", biu_isu_rvalid_o, 1'b0);
        sendBeat(hi_v, 6'd29, 1'b1, 2'b00);
        checkOutput("t1_rvalid", biu_isu_rvalid_o, 1'b1);
        checkOutput("t1_rdata", biu_isu_rdata_o, {hi_v, lo_v});
        checkOutput("t1_rid", biu_isu_rid_o, 6'd29);
        checkOutput("t1_err", biu_err_o, 1'b0);
        drainLine();
        checkOutput("t1_rvalid_drop", biu_isu_rvalid_o, 1'b0);

        // Duplicate ID blocked until the cycle after its ISU handshake
        $display("[TB] duplicate id");
        applyStimulus(32'h0000_1000, 3'd2, 3'd1);
        htu_biu_req_valid_i = 1'b1;
        htu_biu_req_set_i   = 3'd2;
        htu_biu_req_way_i   = 3'd1;
        #1;
        checkOutput("t2_dup_blocked", htu_biu_req_ready_o, 1'b0);
        htu_biu_req_valid_i = 1'b0;
        applyStimulus(32'h0000_2000, 3'd2, 3'd2);
        sendBeat({4{32'h1717_0000}}, 6'd17, 1'b0, 2'b00);
        sendBeat({4{32'h1717_1111}}, 6'd17, 1'b1, 2'b00);
        checkOutput("t2_rid", biu_isu_rid_o, 6'd17);
        htu_biu_req_valid_i = 1'b1;
        htu_biu_req_set_i   = 3'd2;
        htu_biu_req_way_i   = 3'd1;
        #1;
        checkOutput("t2_dup_still_blocked", htu_biu_req_ready_o, 1'b0);
        biu_isu_rready_i = 1'b1;
        #1;
        checkOutput("t2_blocked_during_clear", htu_biu_req_ready_o, 1'b0);
        tick();
        biu_isu_rready_i = 1'b0;
        #1;
        checkOutput("t2_ready_after_clear", htu_biu_req_ready_o, 1'b1);
        checkOutput("t2_rvalid_drop", biu_isu_rvalid_o, 1'b0);
        tick();
        htu_biu_req_valid_i = 1'b0;
        #1;
        doReset();

        // Outstanding limit of 8 with R stalled
        $display("[TB] outstanding limit");
        axi_arready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(32'h0000_4000 + 32'(i * 32), 3'(i >> 3), 3'(i));
        end
        tick();
        tick();
        tick();
        checkOutput("t3_ar_count8", 32'(ar_count), 32'd8);
        checkOutput("t3_arvalid_held", axi_arvalid_o, 1'b0);
        sendBeat({4{32'h0000_00C0}}, 6'd0, 1'b0, 2'b00);
        sendBeat({4{32'h0000_00C1}}, 6'd0, 1'b1, 2'b00);
        checkOutput("t3_line_rid", biu_isu_rid_o, 6'd0);
        checkOutput("t3_arvalid_still_held", axi_arvalid_o, 1'b0);
        drainLine();
        checkOutput("t3_arvalid_release", axi_arvalid_o, 1'b1);
        checkOutput("t3_arid9", axi_arid_o, 6'd8);
        tick();
        checkOutput("t3_ar_count9", 32'(ar_count), 32'd9);
        checkOutput("t3_fifo_drained", axi_arvalid_o, 1'b0);
        doReset();

        // FIFO full with arready low, then in-order drain
        $display("[TB] fifo full");
        axi_arready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h0000_8000 + 32'(k * 32), 3'd1, 3'(k));
        end
        htu_biu_req_valid_i = 1'b1;
        htu_biu_req_addr_i  = 32'h0000_8080;
        htu_biu_req_set_i   = 3'd1;
        htu_biu_req_way_i   = 3'd4;
        #1;
        checkOutput("t4_fifth_blocked", htu_biu_req_ready_o, 1'b0);
        htu_biu_req_valid_i = 1'b0;
        axi_arready_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t4_drain_valid", axi_arvalid_o, 1'b1);
            checkOutput("t4_drain_arid", axi_arid_o, 6'(8 + k));
            checkOutput("t4_drain_araddr", axi_araddr_o, 32'h0000_8000 + 32'(k * 32));
            tick();
        end
        checkOutput("t4_empty", axi_arvalid_o, 1'b0);
        doReset();

        // ISU backpressure, then overlapped ISU handshake and next beat0
        $display("[TB] isu backpressure");
        axi_arready_i = 1'b1;
        applyStimulus(32'h0000_A000, 3'd0, 3'd5);
        applyStimulus(32'h0000_A020, 3'd0, 3'd6);
        lo_v = {4{32'h5555_0000}};
        hi_v = {4{32'h5555_FFFF}};
        sendBeat(lo_v, 6'd5, 1'b0, 2'b00);
        sendBeat(hi_v, 6'd5, 1'b1, 2'b00);
        for (int c = 0; c < 5; c++) begin
            checkOutput("t5_hold_rvalid", biu_isu_rvalid_o, 1'b1);
            checkOutput("t5_hold_rdata", biu_isu_rdata_o, {hi_v, lo_v});
            checkOutput("t5_hold_rid", biu_isu_rid_o, 6'd5);
            checkOutput("t5_hold_rready", axi_rready_o, 1'b0);
            tick();
        end
        lo_v = {4{32'h6666_0000}};
        hi_v = {4{32'h6666_FFFF}};
        axi_rvalid_i = 1'b1;
        axi_rdata_i  = lo_v;
        axi_rid_i    = 6'd6;
        axi_rlast_i  = 1'b0;
        #1;
        checkOutput("t5_beat0_stalled", axi_rready_o, 1'b0);
        biu_isu_rready_i = 1'b1;
        #1;
        checkOutput("t5_rready_follows_isu", axi_rready_o, 1'b1);
        tick();
        axi_rvalid_i = 1'b0;
        biu_isu_rready_i = 1'b0;
        #1;
        checkOutput("t5_rvalid_drop", biu_isu_rvalid_o, 1'b0);
        sendBeat(hi_v, 6'd6, 1'b1, 2'b00);
        checkOutput("t5_line2_rvalid", biu_isu_rvalid_o, 1'b1);
        checkOutput("t5_line2_rdata", biu_isu_rdata_o, {hi_v, lo_v});
        checkOutput("t5_line2_rid", biu_isu_rid_o, 6'd6);
        checkOutput("t5_err", biu_err_o, 1'b0);
        drainLine();
        doReset();

        // Beat0 carrying rlast is dropped and flags an error
        $display("[TB] error cases");
        sendBeat({4{32'hDEAD_0000}}, 6'd1, 1'b1, 2'b00);
        checkOutput("t6_rlast_err", biu_err_o, 1'b1);
        checkOutput("t6_rlast_no_out", biu_isu_rvalid_o, 1'b0);
        lo_v = {4{32'h0C0C_0C0C}};
        hi_v = {4{32'h0D0D_0D0D}};
        sendBeat(lo_v, 6'd1, 1'b0, 2'b00);
        checkOutput("t6_dropped_beat_not_lo", biu_isu_rvalid_o, 1'b0);
        sendBeat(hi_v, 6'd1, 1'b1, 2'b00);
        checkOutput("t6_after_drop_rdata", biu_isu_rdata_o, {hi_v, lo_v});
        checkOutput("t6_err_sticky", biu_err_o, 1'b1);
        drainLine();
        doReset();

        // SLVERR response still delivers the line
        checkOutput("t6_err_cleared", biu_err_o, 1'b0);
        lo_v = {4{32'h0E0E_0E0E}};
        hi_v = {4{32'h0F0F_0F0F}};
        sendBeat(lo_v, 6'd2, 1'b0, 2'b00);
        sendBeat(hi_v, 6'd2, 1'b1, 2'b10);
        checkOutput("t6_resp_rvalid", biu_isu_rvalid_o, 1'b1);
        checkOutput("t6_resp_rdata", biu_isu_rdata_o, {hi_v, lo_v});
        checkOutput("t6_resp_err", biu_err_o, 1'b1);
        drainLine();
        checkOutput("t6_resp_err_sticky", biu_err_o, 1'b1);
        doReset();

        // RID mismatch between beats
        sendBeat({4{32'h1111_1111}}, 6'd3, 1'b0, 2'b00);
        sendBeat({4{32'h2222_2222}}, 6'd4, 1'b1, 2'b00);
        checkOutput("t6_rid_mismatch_err", biu_err_o, 1'b1);
        checkOutput("t6_rid_mismatch_rid", biu_isu_rid_o, 6'd3);
        drainLine();
        doReset();

        // Reset during R_HI drops the partial line
        sendBeat({4{32'h3333_3333}}, 6'd5, 1'b0, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t6_midrst_rvalid", biu_isu_rvalid_o, 1'b0);
        checkOutput("t6_midrst_err", biu_err_o, 1'b0);
        lo_v = {4{32'h4444_4444}};
        hi_v = {4{32'h7777_7777}};
        sendBeat(lo_v, 6'd5, 1'b0, 2'b00);
        checkOutput("t6_midrst_in_rlo", biu_isu_rvalid_o, 1'b0);
        sendBeat(hi_v, 6'd5, 1'b1, 2'b00);
        checkOutput("t6_midrst_rdata", biu_isu_rdata_o, {hi_v, lo_v});
        checkOutput("t6_midrst_err_clean", biu_err_o, 1'b0);
        drainLine();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_biu_linefill_rd.md
Name: bank_biu_linefill_rd

Overview:
Bank-side read half of the BIU. It accepts linefill requests (line address plus set/way) from the HTU and issues one AXI4 two-beat INCR read per line, with ARID = {set,way}. It assembles the two 128-bit R beats into one 256-bit line and presents it to the ISU on the biu_isu_r* interface, where the low half is offset0 and the high half is offset1. It also tracks in-flight set/way IDs so that no ID is ever issued twice concurrently.

Parameters:
ADDR_WIDTH, 32, byte address width of the line address and ARADDR
REQ_DEPTH, 4, request FIFO entries (power of 2, ≥2)
MAX_OUTSTANDING, 8, maximum ARs issued but not yet delivered to the ISU (1..64)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
htu_biu_req_valid_i  input  1  linefill request valid
htu_biu_req_ready_o  output  1  request accepted this cycle when valid&ready
htu_biu_req_addr_i  input  ADDR_WIDTH  line byte address; low 5 bits ignored
htu_biu_req_set_i  input  3  target set
htu_biu_req_way_i  input  3  target way
axi_arvalid_o  output  1  AR valid
axi_arready_i  input  1  AR ready
axi_araddr_o  output  ADDR_WIDTH  {addr[ADDR_WIDTH-1:5],5'b0}
axi_arid_o  output  6  {set,way}
axi_arlen_o  output  8  constant 8'd1
axi_arsize_o  output  3  constant 3'd4
axi_arburst_o  output  2  constant 2'b01
axi_rvalid_i  input  1  R valid
axi_rready_o  output  1  R ready
axi_rdata_i  input  128  R beat data
axi_rid_i  input  6  R id
axi_rlast_i  input  1  R last
axi_rresp_i  input  2  R response
biu_isu_rvalid_o  output  1  assembled line valid
biu_isu_rready_i  input  1  ISU ready
biu_isu_rdata_o  output  256  {beat1,beat0}
biu_isu_rid_o  output  6  {set,way} of the line
biu_err_o  output  1  sticky protocol/response error

Behaviour:
- Reset (rst_i=1 at a posedge): FIFO empty; inflight vector = 0; outstanding counter = 0; R FSM = R_LO; biu_isu_rvalid_o=0, biu_isu_rdata_o=0, biu_isu_rid_o=0, axi_arvalid_o=0, biu_err_o=0. A reset in the middle of a burst drops the partial line with no output. Constant AR fields are driven during reset.
- Enqueue:
  - htu_biu_req_ready_o = !fifo_full & !inflight[{set,way}] & !(clearing this cycle of the same ID).
  - The inflight bit for the ID is set on enqueue, not on AR issue.
- AR issue:
  - axi_arvalid_o = !fifo_empty & (outstanding < MAX_OUTSTANDING).
  - AR fields come from the FIFO head. The head is popped on arvalid&arready.
  - Once asserted, axi_arvalid_o and the AR fields stay stable until arready.
  - The outstanding check is made before arvalid is raised, so arvalid never drops without a handshake.
  - FIFO bypass is not allowed: an enqueued request reaches arvalid no earlier than the next cycle.
- Outstanding counter:
  - +1 on an AR handshake, −1 on an ISU handshake (biu_isu_rvalid_o & biu_isu_rready_i).
  - A simultaneous +1 and −1 leaves it unchanged.
- Inflight clear: the bit for biu_isu_rid_o clears on the ISU handshake.
- R FSM (beats of one burst arrive back-to-back with no interleaving; this is a system requirement):
  - R_LO: axi_rready_o=1. On an R handshake: capture rdata→lo and rid→cur_id, go to R_HI. If rlast=1 here, set err and stay in R_LO (the beat is dropped).
  - R_HI: axi_rready_o=1. On an R handshake: capture rdata→hi. Set err if rid≠cur_id or rlast=0. Load the output register {hi,lo}, rid=cur_id, rvalid=1, go to R_OUT.
  - R_OUT: axi_rready_o = biu_isu_rready_i. On an ISU handshake, rvalid drops, or stays 1 if a new line completes the same cycle (not possible with 2 beats, so rvalid drops). A beat0 accepted in the same cycle goes to R_HI; otherwise the FSM goes to R_LO.
- rresp≠OKAY on either beat sets biu_err_o; the line is still delivered.
- biu_err_o is sticky until reset.
- Latency:
  - HTU accept at cycle N → arvalid at N+1.
  - R beat1 handshake at N → biu_isu_rvalid_o at N+1.
  - Minimum of 2 cycles per line at the R port.
- Outputs are stable while biu_isu_rvalid_o=1 and the ISU is not ready.
- Outstanding counter width is clog2(MAX_OUTSTANDING+1). The FIFO pointers wrap naturally, with one extra bit for full/empty.

Decomposition:
- Shared package bank_biu_pkg: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, LINE_ARLEN=8'd1, LINE_ARSIZE=3'd4, LINE_OFFSET_BITS=5, R FSM state enum {R_LO,R_HI,R_OUT}.
- One sub-module: bank_biu_req_fifo, a parameterised sync FIFO of {addr,set,way} with push/pop/full/empty.

Test Plan:
- Single request addr=0x1234_5660, set=3, way=5 → ARADDR=0x1234_5660, ARID=6'd29, ARLEN=1. Beats 0xA..,0xB.. → rdata={B,A}, rid=29, rvalid one cycle after beat1, err=0.
- Duplicate ID: request set=2/way=1 while the same ID is in flight → ready=0 until the cycle after the ISU handshake for rid=17. Request set=2/way=2 → accepted.
- MAX_OUTSTANDING=8, arready=1, R stalled, 9 unique requests → exactly 8 ARs, the 9th held in the FIFO. One line delivered → 9th AR issued the next cycle.
- FIFO full: arready=0, 5 requests → first 4 accepted, 5th ready=0. Then arready=1 → drains in order, ARIDs match enqueue order.
- ISU backpressure: biu_isu_rready_i=0 for 5 cycles after a line → rdata/rid stable, rready=0. Ready released while beat0 of the next line is valid → both handshakes happen the same cycle, FSM goes to R_HI.
- Errors: beat0 with rlast=1 → err=1, no output. Burst with rresp=2'b10 → line delivered, err stays 1. rst_i during R_HI → no output, err=0, FSM in R_LO.
